// File: rtl/barrel_shifter_pkg.sv
// barrel_shifter_pkg: shared types for the pipelined barrel shifter.
// Optional feature macro: BARREL_SHIFTER_STICKY_EN (adds the sticky flag).
//
// The data, shamt and tag widths follow the top-level parameters. They travel
// as plain vectors beside this control word, which keeps the package usable
// for every WIDTH/TAG_W choice.
package barrel_shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_ASR = 2'b01,
        SH_LSL = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

    // Per-operation control carried with the data through every stage
    typedef struct packed {
        shift_mode_e mode;
        logic        fill;
`ifdef BARREL_SHIFTER_STICKY_EN
        logic        sticky;
`endif
    } stage_ctl_t;

    // Right-shift fill value: operand MSB for ASR, zero for every other mode
    function automatic logic fill_bit(input shift_mode_e mode, input logic msb);
        logic f;
        if (mode == SH_ASR) begin
            f = msb;
        end else begin
            f = 1'b0;
        end
        return f;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// barrel_shift_stage: one registered mux level of the pipelined shifter.
// Shifts by DIST when shamt bit SEL is set, otherwise passes through.
// Optional feature macro: BARREL_SHIFTER_STICKY_EN (accumulates lost bits).
module barrel_shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int TAG_W   = 4,
    parameter int DIST    = 1,
    parameter int SEL     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv_i,
    input  logic               valid_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  stage_ctl_t         ctl_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output stage_ctl_t         ctl_o,
    output logic [TAG_W-1:0]   tag_o
);

    logic               valid_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic [SHAMT_W-1:0] shamt_q;
    stage_ctl_t         ctl_q;
    stage_ctl_t         ctl_d;
    logic [TAG_W-1:0]   tag_q;

    // Mux level: apply this stage's distance when its select bit is set
    always_comb begin
        data_d = data_i;
        if (shamt_i[SEL]) begin
            case (ctl_i.mode)
                SH_LSR, SH_ASR: data_d = {{DIST{ctl_i.fill}}, data_i[WIDTH-1:DIST]};
                SH_LSL:         data_d = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
                SH_ROR:         data_d = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                default:        data_d = data_i;
            endcase
        end else begin
            data_d = data_i;
        end
    end

`ifdef BARREL_SHIFTER_STICKY_EN
    logic lost_s;

    // Sticky: OR in the bits that fall off the end at this level (none for ROR)
    always_comb begin
        ctl_d  = ctl_i;
        lost_s = 1'b0;
        if (shamt_i[SEL]) begin
            case (ctl_i.mode)
                SH_LSR, SH_ASR: lost_s = |data_i[DIST-1:0];
                SH_LSL:         lost_s = |data_i[WIDTH-1:WIDTH-DIST];
                default:        lost_s = 1'b0;
            endcase
        end else begin
            lost_s = 1'b0;
        end
        ctl_d.sticky = ctl_i.sticky | lost_s;
    end
`else
    // Control word passes through unchanged
    always_comb begin
        ctl_d = ctl_i;
    end
`endif

    // Stage registers: all stages move together on adv; payload only for real ops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            ctl_q   <= '0;
            tag_q   <= '0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                ctl_q   <= ctl_d;
                tag_q   <= tag_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign ctl_o   = ctl_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined LSR/ASR/LSL/ROR shifter with valid/ready.
// One registered stage per shamt bit, largest distance first.
// Optional feature macro: BARREL_SHIFTER_STICKY_EN (adds out_sticky).
module barrel_shifter_pipe
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
`ifdef BARREL_SHIFTER_STICKY_EN
    output logic               out_sticky,
`endif
    output logic [TAG_W-1:0]   out_tag
);

    // Index 0 is the accept side; index k+1 is the register output of stage k
    logic               valid_s [0:SHAMT_W];
    logic [WIDTH-1:0]   data_s  [0:SHAMT_W];
    logic [SHAMT_W-1:0] shamt_s [0:SHAMT_W];
    stage_ctl_t         ctl_s   [0:SHAMT_W];
    logic [TAG_W-1:0]   tag_s   [0:SHAMT_W];
    stage_ctl_t         ctl_in_s;
    logic               adv_s;
    logic               unused_s;

    // Entry control word: decode the mode and freeze the ASR fill bit at accept
    always_comb begin
        ctl_in_s      = '0;
        ctl_in_s.mode = shift_mode_e'(in_mode);
        ctl_in_s.fill = fill_bit(shift_mode_e'(in_mode), in_data[WIDTH-1]);
    end

    assign valid_s[0] = in_valid;
    assign data_s[0]  = in_data;
    assign shamt_s[0] = in_shamt;
    assign ctl_s[0]   = ctl_in_s;
    assign tag_s[0]   = in_tag;

    // Whole pipeline advances unless a held result is blocking the output
    assign adv_s    = !valid_s[SHAMT_W] || out_ready;
    assign in_ready = adv_s;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .TAG_W   (TAG_W),
            .DIST    (32'd1 << (SHAMT_W - 1 - k)),
            .SEL     (SHAMT_W - 1 - k)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .adv_i   (adv_s),
            .valid_i (valid_s[k]),
            .data_i  (data_s[k]),
            .shamt_i (shamt_s[k]),
            .ctl_i   (ctl_s[k]),
            .tag_i   (tag_s[k]),
            .valid_o (valid_s[k+1]),
            .data_o  (data_s[k+1]),
            .shamt_o (shamt_s[k+1]),
            .ctl_o   (ctl_s[k+1]),
            .tag_o   (tag_s[k+1])
        );
    end

    assign out_valid = valid_s[SHAMT_W];
    assign out_data  = data_s[SHAMT_W];
    assign out_tag   = tag_s[SHAMT_W];
`ifdef BARREL_SHIFTER_STICKY_EN
    assign out_sticky = ctl_s[SHAMT_W].sticky;
`endif

    // Shift controls are spent once the last stage has used them
    assign unused_s = ^{shamt_s[SHAMT_W], ctl_s[SHAMT_W].mode, ctl_s[SHAMT_W].fill};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: directed and randomized checks against a reference model.
module tb_barrel_shifter_pipe;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;
    localparam int TAG_W   = 4;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
`ifdef BARREL_SHIFTER_STICKY_EN
    logic               out_sticky;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] op_data[$];
    logic [3:0]  op_shamt[$];
    logic [1:0]  op_mode[$];
    logic [3:0]  op_tag[$];
    logic [15:0] res_data[$];
    logic [3:0]  res_tag[$];
    logic        res_sticky[$];
    int          acc_cyc[$];
    int          ret_cyc[$];
    logic        tr_in_ready[$];
    logic        tr_out_valid[$];
    logic [15:0] tr_out_data[$];
    logic [3:0]  tr_out_tag[$];

    barrel_shifter_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef BARREL_SHIFTER_STICKY_EN
        .out_sticky(out_sticky),
`endif
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: shift result from plain arithmetic on the whole operand
    function automatic logic [15:0] model_data(input logic [15:0] d, input int s, input logic [1:0] m);
        logic signed [15:0] sd;
        logic [31:0]        dd;
        sd = d;
        dd = {d, d} >> s;
        case (m)
            2'b00:   return d >> s;
            2'b01:   return sd >>> s;
            2'b10:   return d << s;
            default: return dd[15:0];
        endcase
    endfunction

    // Reference model: did any set bit fall off the end of the word
    function automatic logic model_sticky(input logic [15:0] d, input int s, input logic [1:0] m);
        logic [31:0] w;
        logic [31:0] mask;
        mask = (32'h1 << s) - 32'h1;
        w    = {16'h0, d} << s;
        case (m)
            2'b00, 2'b01: return (({16'h0, d} & mask) != 32'h0);
            2'b10:        return (w[31:16] != 16'h0);
            default:      return 1'b0;
        endcase
    endfunction

    task automatic add_op(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m, input logic [3:0] t);
        op_data.push_back(d);
        op_shamt.push_back(s);
        op_mode.push_back(m);
        op_tag.push_back(t);
    endtask

    task automatic clear_ops();
        op_data.delete();
        op_shamt.delete();
        op_mode.delete();
        op_tag.delete();
    endtask

    // Drives the queued operations and records every retired result and a per-cycle trace
    task automatic run_ops(input int stall_lo, input int stall_hi, input bit rand_ready, input bit rand_gap);
        int cyc;
        int sent;
        int n;
        bit presenting;
        bit fire;
        cyc = 0;
        sent = 0;
        n = op_data.size();
        presenting = 1'b0;
        res_data.delete(); res_tag.delete(); res_sticky.delete();
        acc_cyc.delete(); ret_cyc.delete();
        tr_in_ready.delete(); tr_out_valid.delete(); tr_out_data.delete(); tr_out_tag.delete();
        @(posedge clk); #1;
        while ((sent < n || res_data.size() < n) && cyc < 3000) begin
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            else            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            if (!presenting && sent < n) presenting = rand_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = presenting;
            if (presenting) begin
                in_data  = op_data[sent];
                in_shamt = op_shamt[sent];
                in_mode  = op_mode[sent];
                in_tag   = op_tag[sent];
            end
            @(negedge clk);
            tr_in_ready.push_back(in_ready);
            tr_out_valid.push_back(out_valid);
            tr_out_data.push_back(out_data);
            tr_out_tag.push_back(out_tag);
            fire = in_valid && in_ready;
            if (fire) acc_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                res_data.push_back(out_data);
                res_tag.push_back(out_tag);
`ifdef BARREL_SHIFTER_STICKY_EN
                res_sticky.push_back(out_sticky);
`else
                res_sticky.push_back(1'b0);
`endif
                ret_cyc.push_back(cyc);
            end
            @(posedge clk); #1;
            if (fire) begin
                sent++;
                presenting = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        // Drain: anything retiring now is a duplicate
        repeat (6) begin
            @(negedge clk);
            if (out_valid) begin
                res_data.push_back(out_data);
                res_tag.push_back(out_tag);
                res_sticky.push_back(1'b0);
                ret_cyc.push_back(cyc);
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_lsr_latency();
        int bad;
        clear_ops();
        add_op(16'hF0F0, 4'd4, 2'b00, 4'd5);
        run_ops(99999, 0, 1'b0, 1'b0);
        checks++;
        if (res_data.size() != 1 || acc_cyc.size() != 1) begin
            errors++; $display("FAIL lsr_count got=%0d exp=1", res_data.size());
        end else begin
            checks++; if (res_data[0] !== 16'h0F0F) begin errors++; $display("FAIL lsr_data got=%h exp=0f0f", res_data[0]); end
            checks++; if (res_tag[0] !== 4'd5) begin errors++; $display("FAIL lsr_tag got=%0d exp=5", res_tag[0]); end
            checks++; if (ret_cyc[0] - acc_cyc[0] != SHAMT_W) begin errors++; $display("FAIL lsr_latency got=%0d exp=%0d", ret_cyc[0] - acc_cyc[0], SHAMT_W); end
            bad = 0;
            for (int c = acc_cyc[0] + 1; c < ret_cyc[0] && c < tr_out_valid.size(); c++) if (tr_out_valid[c] !== 1'b0) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL lsr_early_valid got=%0d cycles exp=0", bad); end
        end
    endtask

    task automatic test_asr_lsr();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'hFFFF; exp_d[1] = 16'h0001; exp_d[2] = 16'h0800;
        clear_ops();
        add_op(16'h8000, 4'd15, 2'b01, 4'd7);
        add_op(16'h8000, 4'd15, 2'b00, 4'd8);
        add_op(16'h4000, 4'd3,  2'b01, 4'd9);
        run_ops(99999, 0, 1'b0, 1'b0);
        checks++;
        if (res_data.size() != 3) begin
            errors++; $display("FAIL asr_count got=%0d exp=3", res_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (res_data[i] !== exp_d[i]) begin errors++; $display("FAIL asr_data[%0d] got=%h exp=%h", i, res_data[i], exp_d[i]); end
                checks++; if (res_tag[i] !== 4'(7 + i)) begin errors++; $display("FAIL asr_tag[%0d] got=%0d exp=%0d", i, res_tag[i], 7 + i); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h8000; exp_d[1] = 16'h8000; exp_d[2] = 16'h3412;
        clear_ops();
        add_op(16'h0001, 4'd15, 2'b10, 4'd1);
        add_op(16'h0001, 4'd1,  2'b11, 4'd2);
        add_op(16'h1234, 4'd8,  2'b11, 4'd3);
        run_ops(99999, 0, 1'b0, 1'b0);
        checks++;
        if (res_data.size() != 3) begin
            errors++; $display("FAIL b2b_count got=%0d exp=3", res_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (res_data[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, res_data[i], exp_d[i]); end
                checks++; if (res_tag[i] !== 4'(i + 1)) begin errors++; $display("FAIL b2b_tag[%0d] got=%0d exp=%0d", i, res_tag[i], i + 1); end
            end
            checks++; if (ret_cyc[2] - ret_cyc[0] != 2) begin errors++; $display("FAIL b2b_throughput got=%0d exp=2", ret_cyc[2] - ret_cyc[0]); end
        end
    endtask

    task automatic test_stall();
        clear_ops();
        for (int i = 0; i < 8; i++) add_op(16'($urandom), 4'($urandom), 2'($urandom), 4'(i));
        run_ops(5, 8, 1'b0, 1'b0);
        checks++;
        if (tr_in_ready.size() < 9) begin
            errors++; $display("FAIL stall_trace got=%0d exp>=9", tr_in_ready.size());
        end else begin
            checks++; if (tr_out_tag[5] !== 4'd1) begin errors++; $display("FAIL stall_head_tag got=%0d exp=1", tr_out_tag[5]); end
            for (int c = 5; c <= 8; c++) begin
                checks++; if (tr_in_ready[c] !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", c, tr_in_ready[c]); end
            end
            for (int c = 6; c <= 8; c++) begin
                checks++;
                if (tr_out_data[c] !== tr_out_data[5] || tr_out_tag[c] !== tr_out_tag[5]) begin
                    errors++; $display("FAIL stall_hold[%0d] got=%h/%0d exp=%h/%0d", c, tr_out_data[c], tr_out_tag[c], tr_out_data[5], tr_out_tag[5]);
                end
            end
        end
        checks++;
        if (res_data.size() != 8) begin
            errors++; $display("FAIL stall_count got=%0d exp=8", res_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (res_data[i] !== model_data(op_data[i], op_shamt[i], op_mode[i]) || res_tag[i] !== op_tag[i]) begin
                    errors++; $display("FAIL stall_result[%0d] got=%h/%0d exp=%h/%0d", i, res_data[i], res_tag[i],
                                       model_data(op_data[i], op_shamt[i], op_mode[i]), op_tag[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 2; round++) begin
            clear_ops();
            for (int i = 0; i < 50; i++) add_op(16'($urandom), 4'($urandom), 2'($urandom), 4'(i));
            run_ops(99999, 0, 1'b1, 1'b1);
            checks++;
            if (res_data.size() != 50) begin
                errors++; $display("FAIL rand_count got=%0d exp=50", res_data.size());
            end else begin
                for (int i = 0; i < 50; i++) begin
                    checks++;
                    if (res_data[i] !== model_data(op_data[i], op_shamt[i], op_mode[i]) || res_tag[i] !== op_tag[i]) begin
                        errors++; $display("FAIL rand_result[%0d] op=%h s=%0d m=%0d got=%h/%0d exp=%h/%0d", i, op_data[i], op_shamt[i], op_mode[i],
                                           res_data[i], res_tag[i], model_data(op_data[i], op_shamt[i], op_mode[i]), op_tag[i]);
                    end
`ifdef BARREL_SHIFTER_STICKY_EN
                    checks++;
                    if (res_sticky[i] !== model_sticky(op_data[i], op_shamt[i], op_mode[i])) begin
                        errors++; $display("FAIL rand_sticky[%0d] got=%b exp=%b", i, res_sticky[i], model_sticky(op_data[i], op_shamt[i], op_mode[i]));
                    end
`endif
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int waited;
        int seen;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'hA5A5 + 16'(i); in_shamt = 4'(i + 1); in_mode = 2'b00; in_tag = 4'(10 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_fill got=%b exp=1", out_valid); end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0 || out_tag !== 4'h0) begin errors++; $display("FAIL midrst_async_data got=%h/%0d exp=0000/0", out_data, out_tag); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale got=%0d cycles exp=0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    endtask

`ifdef BARREL_SHIFTER_STICKY_EN
    task automatic test_sticky();
        logic [15:0] exp_d [3];
        logic        exp_s [3];
        exp_d[0] = 16'h0001; exp_s[0] = 1'b1;
        exp_d[1] = 16'h0000; exp_s[1] = 1'b1;
        exp_d[2] = 16'hFFFF; exp_s[2] = 1'b0;
        clear_ops();
        add_op(16'h0003, 4'd1, 2'b00, 4'd1);
        add_op(16'h8000, 4'd1, 2'b10, 4'd2);
        add_op(16'hFFFF, 4'd0, 2'b00, 4'd3);
        run_ops(99999, 0, 1'b0, 1'b0);
        checks++;
        if (res_data.size() != 3) begin
            errors++; $display("FAIL sticky_count got=%0d exp=3", res_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (res_data[i] !== exp_d[i] || res_sticky[i] !== exp_s[i]) begin
                    errors++; $display("FAIL sticky[%0d] got=%h/%b exp=%h/%b", i, res_data[i], res_sticky[i], exp_d[i], exp_s[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lsr_latency();
        test_asr_lsr();
        test_back_to_back();
        test_stall();
        test_random();
`ifdef BARREL_SHIFTER_STICKY_EN
        test_sticky();
`endif
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined successor to the team's 16-bit combinational logarithmic right shifter.
- Supports four modes: logical right, arithmetic right, logical left and rotate right.
- One registered mux stage per shift-amount bit, from largest distance to smallest (WIDTH/2, ..., 2, 1).
- Valid/ready handshake on both sides; sits between the ALU operand mux and the writeback register.

Parameters:
- WIDTH, 16: data width; power of two, at least 4.
- SHAMT_W, $clog2(WIDTH): shift-amount width; also the number of pipeline stages.
- TAG_W, 4: width of the user tag carried alongside each operation, unmodified.

Ports:
- clk, input, 1: the single clock.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: an operation is presented.
- in_ready, output, 1: the block can accept an operation this cycle.
- in_data, input, WIDTH: operand.
- in_shamt, input, SHAMT_W: shift amount, 0..WIDTH-1.
- in_mode, input, 2: 00 LSR, 01 ASR, 10 LSL, 11 ROR.
- in_tag, input, TAG_W: user tag.
- out_valid, output, 1: a result is presented.
- out_ready, input, 1: the consumer accepts the result.
- out_data, output, WIDTH: shifted result.
- out_tag, output, TAG_W: tag of that result.

Behaviour:
- Reset, asserted at any time:
  - All stage valid flags, data, shamt, mode and tag registers clear immediately, without waiting for a clock edge.
  - out_valid=0, out_data=0, out_tag=0.
  - in_ready=1 once reset is released.
  - Operations in flight are dropped; no stale result appears after reset is released.
- Pipeline enable: adv = !out_valid || out_ready. All stages advance together when adv=1 and hold when adv=0.
- in_ready = adv, combinational. An operation is accepted on a clock edge where in_valid && in_ready.
- Latency: exactly SHAMT_W cycles from accept to out_valid, when the block is not stalled.
- Throughput: one operation per cycle. Up to SHAMT_W operations may be in flight.
- Bubbles travel with the pipeline. They are not collapsed.
- Stage k (k=0..SHAMT_W-1):
  - Distance d = 2^(SHAMT_W-1-k). The stage uses select bit shamt[SHAMT_W-1-k].
  - If the select bit is 0, the stage passes its input through.
  - LSR: result[i] = src[i+d], or 0 where i+d >= WIDTH.
  - ASR: as LSR, but the fill value is the operand MSB captured at accept time. Use this MSB, not the current MSB of the stage input.
  - LSL: result[i] = src[i-d], or 0 where i < d.
  - ROR: result[i] = src[(i+d) mod WIDTH].
- Mode and shamt are captured at accept and travel with the data. Each stage uses only its own bit. Mixed modes back-to-back are legal.
- shamt=0 gives a pass-through, still with latency SHAMT_W.
- Ordering is strict FIFO. out_tag always equals the in_tag of the same operation.
- Simultaneous accept and retire in one cycle are both honoured.
- in_valid while in_ready=0: nothing is captured. The upstream holds its operation.
- out_data and out_tag are stable while out_valid && !out_ready.

Optional Feature:
- Macro: BARREL_SHIFTER_STICKY_EN.
- When defined:
  - Adds output out_sticky, 1 bit.
  - For LSR and ASR, out_sticky is the OR of all bits shifted out below bit 0.
  - For LSL, out_sticky is the OR of all bits shifted out above the MSB.
  - For ROR, out_sticky=0.
  - It is accumulated per stage, travels with the data, and resets to 0.
- When not defined: the port and all sticky flops are absent, and the rest of the behaviour is identical.

Decomposition:
- Package barrel_shifter_pkg holds:
  - mode enum shift_mode_e {SH_LSR=2'b00, SH_ASR=2'b01, SH_LSL=2'b10, SH_ROR=2'b11};
  - the stage-payload struct: data, shamt, mode, fill bit, tag, and sticky.
- Sub-module barrel_shift_stage:
  - parameters WIDTH and DIST, plus select index;
  - implements one mux level plus its registers and valid flag;
  - the top level instantiates it SHAMT_W times with a generate loop.

Test Plan:
- WIDTH=16, LSR, in_data=16'hF0F0, shamt=4, out_ready=1 -> out_data=16'h0F0F, with out_valid exactly 4 cycles after accept.
- ASR in_data=16'h8000, shamt=15 -> 16'hFFFF. Then LSR with the same operands -> 16'h0001. Then ASR in_data=16'h4000, shamt=3 -> 16'h0800.
- LSL 16'h0001, shamt=15 -> 16'h8000. Then ROR 16'h0001, shamt=1 -> 16'h8000. Then ROR 16'h1234, shamt=8 -> 16'h3412. Issue these back to back with tags 1, 2, 3; they retire in tag order.
- Stall test:
  - Stimulus: stream 8 operations with tags 0..7, holding out_ready=0 for cycles 5..8.
  - Required: in_ready=0 during the stall and out_data/out_tag held stable.
  - Required: all 8 results retire in order with correct values, none lost or duplicated.
- Reset test:
  - Stimulus: assert reset mid-cycle with 3 operations in flight.
  - Required: out_valid drops to 0 without waiting for a clock edge.
  - Required: after release, with no new input, out_valid stays 0 for 10 cycles.
- With BARREL_SHIFTER_STICKY_EN defined:
  - LSR 16'h0003, shamt=1 -> out_data=16'h0001, out_sticky=1.
  - LSL 16'h8000, shamt=1 -> 16'h0000, out_sticky=1.
  - shamt=0 -> out_sticky=0.
